sort_readback: RTL and testbench

SORT_READBACK -- requirements
Module: sort_readback

---
 rtl/sort_readback.sv | 137 +++++++++++++
 tb/tb_sort_readback.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sort_readback.sv
// Streams sorted elements back from DRAM: issues block reads under FIFO credit,
// serializes each word LSB-first to TX, checks ascending order, then sends PCNT.
module sort_readback #(
  parameter int         APPDATA_W = 512,
  parameter int         ELEM_W    = 32,
  parameter int         VBLOCKS   = 4,
  parameter int         FIFO_LOG  = 4,
  parameter int         STRIDE    = 32,
  parameter logic [1:0] REQ_READ  = 2'b10,
  parameter int         SHOWNUM   = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [31:0]          BASE_ADR,
  input  logic [31:0]          NUM_ELEM,
  input  logic [31:0]          PCNT,
  input  logic                 D_BUSY,
  output logic [1:0]           D_REQ,
  output logic [31:0]          D_INITADR,
  output logic [31:0]          D_ELEM,
  input  logic [APPDATA_W-1:0] D_DOUT,
  input  logic                 D_DOUTEN,
  output logic [ELEM_W-1:0]    TX_DATA,
  output logic                 TX_WE,
  input  logic                 TX_RDY,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ORDER_ERR,
  output logic [31:0]          ERR_CNT
);
  localparam int EPW     = APPDATA_W / ELEM_W;
  localparam int EW      = (EPW > 1) ? $clog2(EPW) : 1;
  localparam int DEPTH   = 1 << FIFO_LOG;
  localparam int PER_REQ = EPW * VBLOCKS;
  localparam logic [FIFO_LOG:0] VB = (FIFO_LOG+1)'(VBLOCKS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_JUDGE   = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_READING = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_SENDP   = 3'd5;
  localparam logic [2:0] S_FIN     = 3'd6;

  logic [2:0]           state;
  logic [31:0]          adr, num_q, pcnt_q, req_left, consumed, sent;
  logic [FIFO_LOG:0]    cnt, inflight;
  logic [FIFO_LOG-1:0]  wr_ptr, rd_ptr;
  logic [APPDATA_W-1:0] mem [DEPTH];
  logic [EW-1:0]        eidx;
  logic [ELEM_W-1:0]    prev, elem;
  logic start_ok, req_fire, enq, deq, step, show, active, credit_ok;

  assign start_ok  = START && (state == S_IDLE || state == S_FIN);
  assign req_fire  = (state == S_REQ) && !D_BUSY;
  // Data with no outstanding request (e.g. left over from an aborted run) is dropped.
  assign enq       = D_DOUTEN && (inflight != '0);
  assign active    = (state == S_JUDGE) || (state == S_REQ) ||
                     (state == S_READING) || (state == S_DRAIN);
  assign elem      = mem[rd_ptr][eidx*ELEM_W +: ELEM_W];
  assign show      = sent < 32'(SHOWNUM);
  assign step      = active && (cnt != '0) && (!show || TX_RDY);
  assign deq       = step && (eidx == EW'(EPW-1));
  assign credit_ok = (32'(DEPTH) - 32'(cnt)) >= (32'(inflight) + 32'(VBLOCKS));

  assign D_REQ     = req_fire ? REQ_READ : 2'b00;
  assign D_INITADR = req_fire ? adr : 32'd0;
  assign D_ELEM    = req_fire ? 32'(VBLOCKS) : 32'd0;
  assign TX_WE     = (step && show) || (state == S_SENDP && TX_RDY);
  assign TX_DATA   = !TX_WE ? '0 : (state == S_SENDP) ? ELEM_W'(pcnt_q) : elem;
  assign BUSY      = (state != S_IDLE) && (state != S_FIN);
  assign DONE      = (state == S_FIN);

  always_ff @(posedge CLK)
    if (!RST && enq) mem[wr_ptr] <= D_DOUT;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      adr       <= '0; num_q    <= '0; pcnt_q   <= '0; req_left <= '0;
      consumed  <= '0; sent     <= '0; cnt      <= '0; inflight <= '0;
      wr_ptr    <= '0; rd_ptr   <= '0; eidx     <= '0; prev     <= '0;
      ORDER_ERR <= 1'b0;
      ERR_CNT   <= '0;
    end else begin
      if (start_ok) begin
        adr       <= BASE_ADR;
        num_q     <= NUM_ELEM;
        pcnt_q    <= PCNT;
        req_left  <= NUM_ELEM / 32'(PER_REQ);
        consumed  <= '0; sent   <= '0; cnt  <= '0; inflight <= '0;
        wr_ptr    <= '0; rd_ptr <= '0; eidx <= '0;
        ORDER_ERR <= 1'b0;
        ERR_CNT   <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + 1'b1;
        if (deq) rd_ptr <= rd_ptr + 1'b1;
        cnt      <= cnt + {{FIFO_LOG{1'b0}}, enq} - {{FIFO_LOG{1'b0}}, deq};
        inflight <= inflight + (req_fire ? VB : '0) - {{FIFO_LOG{1'b0}}, enq};
        if (req_fire) begin
          adr      <= adr + 32'(STRIDE);
          req_left <= req_left - 32'd1;
        end
        if (step) begin
          eidx     <= deq ? '0 : eidx + 1'b1;
          consumed <= consumed + 32'd1;
          prev     <= elem;
          if (show) sent <= sent + 32'd1;
          if (consumed != '0 && elem < prev) begin
            ORDER_ERR <= 1'b1;
            if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + 32'd1;
          end
        end
      end

      case (state)
        S_IDLE, S_FIN:
          if (START) state <= (NUM_ELEM == '0) ? S_SENDP : S_JUDGE;
        S_JUDGE:
          if (req_left == '0)             state <= S_DRAIN;
          else if (!D_BUSY && credit_ok)  state <= S_REQ;
        S_REQ:
          if (!D_BUSY) state <= S_READING;
        // With requests outstanding, wait out D_BUSY rather than drain early.
        S_READING:
          if (req_left == '0) state <= S_DRAIN;
          else if (!D_BUSY)   state <= S_JUDGE;
        S_DRAIN:
          if (consumed == num_q) state <= S_SENDP;
        S_SENDP:
          if (TX_RDY) state <= S_FIN;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_readback.sv
// Directed bench for sort_readback: DRAM/TX model at negedge, hand-derived expectations.
module tb_sort_readback;
  localparam int APPDATA_W = 512, ELEM_W = 32, VBLOCKS = 4, FIFO_LOG = 4;
  localparam int STRIDE = 32, SHOWNUM = 1024, EPW = 16, DEPTH = 16;

  logic CLK = 1'b0, RST, START, D_BUSY, D_DOUTEN, TX_RDY, TX_WE, BUSY, DONE, ORDER_ERR;
  logic [31:0] BASE_ADR, NUM_ELEM, PCNT, D_INITADR, D_ELEM, ERR_CNT;
  logic [1:0]  D_REQ;
  logic [APPDATA_W-1:0] D_DOUT;
  logic [ELEM_W-1:0]    TX_DATA;

  sort_readback dut (
    .CLK(CLK), .RST(RST), .START(START), .BASE_ADR(BASE_ADR), .NUM_ELEM(NUM_ELEM),
    .PCNT(PCNT), .D_BUSY(D_BUSY), .D_REQ(D_REQ), .D_INITADR(D_INITADR), .D_ELEM(D_ELEM),
    .D_DOUT(D_DOUT), .D_DOUTEN(D_DOUTEN), .TX_DATA(TX_DATA), .TX_WE(TX_WE),
    .TX_RDY(TX_RDY), .BUSY(BUSY), .DONE(DONE), .ORDER_ERR(ORDER_ERR), .ERR_CNT(ERR_CNT));

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  bit bp_mode = 0, swap_en = 0;
  logic [31:0] base_q = '0;
  int word_q[$];
  logic [31:0] tx_q[$];
  int req_cnt, addr_err, we_bad, cred_bad, outstanding, delivered, cyc;

  function automatic logic [APPDATA_W-1:0] mk_word(input int w);
    logic [APPDATA_W-1:0] r;
    int e;
    r = '0;
    for (int i = 0; i < EPW; i++) begin
      e = w*EPW + i;
      if (swap_en && e == 100)      e = 101;
      else if (swap_en && e == 101) e = 100;
      r[i*ELEM_W +: ELEM_W] = e;
    end
    return r;
  endfunction

  // DRAM + TX sink model: drive at negedge, observe settled outputs 1ns later.
  always @(negedge CLK) begin
    cyc++;
    TX_RDY = bp_mode ? (cyc % 8 == 0) : 1'b1;
    D_BUSY = bp_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
    if (word_q.size() > 0 && (!bp_mode || $urandom_range(0, 2) != 0)) begin
      D_DOUTEN = 1'b1;
      D_DOUT   = mk_word(word_q.pop_front());
      outstanding--;
      delivered++;
    end else begin
      D_DOUTEN = 1'b0;
      D_DOUT   = '0;
    end
    #1;
    if (D_REQ == 2'b10) begin
      if (D_ELEM != 32'(VBLOCKS)) addr_err++;
      if (D_INITADR != base_q + 32'(STRIDE*req_cnt)) addr_err++;
      if (tx_q.size() < SHOWNUM &&
          delivered - tx_q.size()/EPW + outstanding + VBLOCKS > DEPTH) cred_bad++;
      for (int j = 0; j < VBLOCKS; j++)
        word_q.push_back(int'((D_INITADR - base_q) / STRIDE) * VBLOCKS + j);
      req_cnt++;
      outstanding += VBLOCKS;
    end else if (D_REQ != 2'b00) addr_err++;
    if (TX_WE) begin
      if (!TX_RDY) we_bad++;
      tx_q.push_back(TX_DATA);
    end
  end

  task automatic launch(input logic [31:0] base, input logic [31:0] n, input logic [31:0] p);
    @(negedge CLK);
    base_q = base; BASE_ADR = base; NUM_ELEM = n; PCNT = p;
    tx_q.delete();
    req_cnt = 0; addr_err = 0; we_bad = 0; cred_bad = 0; delivered = 0; outstanding = 0;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("busy_after_start", BUSY, 1'b1);
  endtask

  task automatic run(input string nm, input logic [31:0] n, input logic [31:0] p,
                     input bit stray);
    int sc;
    bit done_seen;
    sc = 0; done_seen = 0;
    launch(32'h0000_1000, n, p);
    for (int c = 0; c < 30000; c++) begin
      @(negedge CLK);
      if (DONE) begin done_seen = 1; break; end
      if (stray && req_cnt == int'(n/64)) begin
        sc++;
        if (sc == 4) begin BASE_ADR = '0; NUM_ELEM = '0; START = 1'b1; end
        if (sc == 5) START = 1'b0;
      end
    end
    chk({nm, "_done_in_time"}, done_seen, 1'b1);
  endtask

  task automatic verify(input string nm, input int n, input logic [31:0] p,
                        input bit swp, input logic [31:0] exp_err);
    int shown, mism;
    logic [31:0] v;
    shown = (n < SHOWNUM) ? n : SHOWNUM;
    mism = 0;
    chk({nm, "_tx_count"}, tx_q.size(), shown + 1);
    for (int i = 0; i < shown && i < tx_q.size(); i++) begin
      v = i;
      if (swp && i == 100) v = 101;
      else if (swp && i == 101) v = 100;
      if (tx_q[i] !== v) mism++;
    end
    chk({nm, "_elem_mismatches"}, mism, 0);
    if (tx_q.size() > 0) chk({nm, "_pcnt"}, tx_q[tx_q.size()-1], p);
    chk({nm, "_req_count"}, req_cnt, n/64);
    chk({nm, "_req_fields"}, addr_err, 0);
    chk({nm, "_we_without_rdy"}, we_bad, 0);
    chk({nm, "_credit"}, cred_bad, 0);
    chk({nm, "_order_err"}, ORDER_ERR, exp_err != 0);
    chk({nm, "_err_cnt"}, ERR_CNT, exp_err);
    chk({nm, "_done"}, DONE, 1'b1);
    chk({nm, "_busy_end"}, BUSY, 1'b0);
  endtask

  initial begin
    bit rst_ok;
    RST = 1'b1; START = 1'b0; BASE_ADR = '0; NUM_ELEM = '0; PCNT = '0;
    D_BUSY = 1'b0; D_DOUTEN = 1'b0; D_DOUT = '0; TX_RDY = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_d_req", D_REQ, 2'b00);
    chk("rst_d_initadr", D_INITADR, 32'd0);
    chk("rst_d_elem", D_ELEM, 32'd0);
    chk("rst_tx_we", TX_WE, 1'b0);
    chk("rst_tx_data", TX_DATA, 32'd0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_order_err", ORDER_ERR, 1'b0);
    chk("rst_err_cnt", ERR_CNT, 32'd0);

    run("asc", 2048, 32'h0000_ABCD, 0);
    verify("asc", 2048, 32'h0000_ABCD, 0, 0);

    swap_en = 1;
    run("swap", 2048, 32'h0000_5555, 0);
    verify("swap", 2048, 32'h0000_5555, 1, 1);
    swap_en = 0;

    bp_mode = 1;
    run("bp", 2048, 32'h0000_ABCD, 0);
    verify("bp", 2048, 32'h0000_ABCD, 0, 0);
    bp_mode = 0;

    run("zero", 0, 32'h0000_1234, 0);
    verify("zero", 0, 32'h0000_1234, 0, 0);

    // Abort mid-transfer, then restart cleanly.
    launch(32'h0000_1000, 2048, 32'h0000_0777);
    for (int c = 0; c < 2000 && req_cnt < 3; c++) @(negedge CLK);
    chk("abort_reached_reading", req_cnt >= 3, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_d_req", D_REQ, 2'b00);
    chk("abort_d_initadr", D_INITADR, 32'd0);
    chk("abort_tx_we", TX_WE, 1'b0);
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_done", DONE, 1'b0);
    RST = 1'b0;
    rst_ok = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge CLK);
      if (word_q.size() == 0) begin rst_ok = 1; break; end
    end
    repeat (4) @(negedge CLK);
    chk("abort_dram_idle", rst_ok, 1'b1);
    run("after_rst", 2048, 32'h0000_0777, 0);
    verify("after_rst", 2048, 32'h0000_0777, 0, 0);

    run("stray", 2048, 32'h0000_ABCD, 1);
    verify("stray", 2048, 32'h0000_ABCD, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
